// File: rtl/noc_link_retimer_pkg.sv
// noc_link_retimer_pkg: shared link defaults, VC index type and arbiter states
package noc_link_retimer_pkg;
  localparam int NUM_VC_DEF = 2;
  localparam int FLIT_W_DEF = 64;
  function automatic int vc_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef logic [vc_w(NUM_VC_DEF)-1:0] vc_t;
  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;
endpackage

// File: rtl/noc_link_retimer_vc_fifo.sv
// noc_vc_fifo: single-VC far-end buffer; head is always visible on dout
module noc_vc_fifo #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 64
) (
  input  logic             noc_clk,
  input  logic             noc_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;
  assign dout  = r_mem[r_rd];
  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == CW'(DEPTH));
  always_ff @(posedge noc_clk) begin
    if (push) r_mem[r_wr] <= din;
  end
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
      if (pop) r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(push) - CW'(pop);
    end
  end
  always @(posedge noc_clk) begin
    if (!noc_rst) begin
      assert (!(push && full));
      assert (!(pop && empty));
    end
  end
endmodule

// File: rtl/noc_link_retimer.sv
// noc_link_retimer: credit-managed multi-stage link with per-VC far-end FIFOs
// and a round-robin output arbiter that holds its pick until accepted.
module noc_link_retimer
  import noc_link_retimer_pkg::*;
#(
  parameter int NUM_VC     = NUM_VC_DEF,
  parameter int FLIT_WIDTH = FLIT_W_DEF,
  parameter int STAGES     = 2,
  parameter int BUF_DEPTH  = 6,
  localparam int VW        = vc_w(NUM_VC)
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic                  in_valid,
  input  logic [VW-1:0]         in_vc,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  output logic                  in_ready,
  output logic [NUM_VC-1:0]     in_vc_ready,
  output logic                  out_valid,
  output logic [VW-1:0]         out_vc,
  output logic [FLIT_WIDTH-1:0] out_flit,
  input  logic                  out_ready,
  input  logic [NUM_VC-1:0]     out_vc_ready
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic                  r_fv  [STAGES];
  logic [VW-1:0]         r_fvc [STAGES];
  logic [FLIT_WIDTH-1:0] r_ff  [STAGES];
  logic                  r_rv  [STAGES];
  logic [VW-1:0]         r_rvc [STAGES];
  logic [CW-1:0]         r_cred [NUM_VC];
  logic [CW-1:0]         w_cred_n [NUM_VC];
  logic [NUM_VC-1:0]     r_rdy;
  arb_state_e            r_st, w_st_n;
  logic [VW-1:0]         r_lock, r_last, w_pick, w_sel;
  logic                  w_any, w_acc, w_pop;
  logic [NUM_VC-1:0]     w_push, w_pop_v, w_empty, w_full, w_elig;
  logic [FLIT_WIDTH-1:0] w_dout [NUM_VC];
  int                    w_held [NUM_VC];
  assign in_vc_ready = r_rdy;
  assign in_ready    = r_rdy[in_vc];
  assign w_acc       = in_valid & in_ready;
  assign w_elig      = ~w_empty & out_vc_ready;
  assign out_flit    = w_dout[w_sel];
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_fv[k]  <= 1'b0;
        r_fvc[k] <= '0;
        r_ff[k]  <= '0;
        r_rv[k]  <= 1'b0;
        r_rvc[k] <= '0;
      end
    end else begin
      r_fv[0]  <= w_acc;
      r_fvc[0] <= in_vc;
      r_ff[0]  <= in_flit;
      r_rv[0]  <= w_pop;
      r_rvc[0] <= w_sel;
      for (int k = 1; k < STAGES; k++) begin
        r_fv[k]  <= r_fv[k-1];
        r_fvc[k] <= r_fvc[k-1];
        r_ff[k]  <= r_ff[k-1];
        r_rv[k]  <= r_rv[k-1];
        r_rvc[k] <= r_rvc[k-1];
      end
    end
  end
  // An accept and a return on the same VC cancel out
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_push[v]   = r_fv[STAGES-1] && (r_fvc[STAGES-1] == VW'(v));
      w_pop_v[v]  = w_pop && (w_sel == VW'(v));
      w_cred_n[v] = r_cred[v] + CW'(r_rv[STAGES-1] && (r_rvc[STAGES-1] == VW'(v)))
                  - CW'(w_acc && (in_vc == VW'(v)));
    end
  end
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      for (int v = 0; v < NUM_VC; v++) r_cred[v] <= CW'(BUF_DEPTH);
      r_rdy <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_cred[v] <= w_cred_n[v];
        r_rdy[v]  <= (w_cred_n[v] != '0);
      end
    end
  end
  for (genvar g = 0; g < NUM_VC; g++) begin : g_fifo
    noc_vc_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(FLIT_WIDTH)) u_fifo (
      .noc_clk (noc_clk),
      .noc_rst (noc_rst),
      .push    (w_push[g]),
      .pop     (w_pop_v[g]),
      .din     (r_ff[STAGES-1]),
      .dout    (w_dout[g]),
      .empty   (w_empty[g]),
      .full    (w_full[g])
    );
  end
  // Scan farthest-first so the last hit is the nearest VC after r_last
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last;
    for (int i = NUM_VC; i >= 1; i--) begin
      if (w_elig[(int'(r_last) + i) % NUM_VC]) begin
        w_any  = 1'b1;
        w_pick = VW'((int'(r_last) + i) % NUM_VC);
      end
    end
  end
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      r_st   <= ARB_IDLE;
      r_lock <= '0;
      r_last <= '0;
    end else begin
      r_st <= w_st_n;
      if (r_st == ARB_IDLE) r_lock <= w_pick;
      if (w_pop) r_last <= w_sel;
    end
  end
  always_comb begin
    w_st_n = (r_st == ARB_IDLE) ? ((w_any && !out_ready) ? ARB_HOLD : ARB_IDLE)
                                : (out_ready ? ARB_IDLE : ARB_HOLD);
  end
  always_comb begin
    w_sel     = (r_st == ARB_HOLD) ? r_lock : w_pick;
    out_valid = (r_st == ARB_HOLD) | w_any;
    out_vc    = w_sel;
    w_pop     = out_valid & out_ready;
  end
  // Credits plus flits in both pipes; FIFO occupancy makes up the rest of BUF_DEPTH
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_held[v] = int'(r_cred[v]);
      for (int k = 0; k < STAGES; k++) begin
        w_held[v] += int'(r_fv[k] && (r_fvc[k] == VW'(v)));
        w_held[v] += int'(r_rv[k] && (r_rvc[k] == VW'(v)));
      end
    end
  end
  always @(posedge noc_clk) begin
    if (!noc_rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        assert (r_cred[v] <= CW'(BUF_DEPTH));
        assert (w_held[v] <= BUF_DEPTH);
        if (w_empty[v]) assert (w_held[v] == BUF_DEPTH);
        if (w_full[v]) assert (w_held[v] == 0);
      end
    end
  end
endmodule

// File: tb/tb_noc_link_retimer.sv
// tb_noc_link_retimer: directed vector table, corner sequences and a
// queue-based reference model under random traffic.
module tb_noc_link_retimer;
  localparam int NV = 2;
  localparam int FW = 64;
  localparam int ST = 2;
  localparam int BD = 6;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iv = 1'b0;
  logic [0:0]    ivc = '0;
  logic [FW-1:0] iflit = '0;
  logic          irdy;
  logic [NV-1:0] ivr;
  logic          ov;
  logic [0:0]    ovc;
  logic [FW-1:0] oflit;
  logic          ordy = 1'b0;
  logic [NV-1:0] ovr = '0;
  noc_link_retimer #(.NUM_VC(NV), .FLIT_WIDTH(FW), .STAGES(ST), .BUF_DEPTH(BD)) dut (
    .noc_clk      (clk),
    .noc_rst      (rst),
    .in_valid     (iv),
    .in_vc        (ivc),
    .in_flit      (iflit),
    .in_ready     (irdy),
    .in_vc_ready  (ivr),
    .out_valid    (ov),
    .out_vc       (ovc),
    .out_flit     (oflit),
    .out_ready    (ordy),
    .out_vc_ready (ovr)
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  typedef struct {
    logic        iv;
    logic        vc;
    logic [63:0] f;
    logic        ordy;
    logic [1:0]  ovr;
    logic        eov;
    logic        evc;
    logic [63:0] ef;
    logic [1:0]  eivr;
  } vec_t;
  vec_t tbl[22];
  function automatic vec_t mk(int a, int b, longint c, int d, int e, int f, int g, longint h, int i);
    vec_t r;
    r.iv = 1'(a); r.vc = 1'(b); r.f = 64'(c); r.ordy = 1'(d); r.ovr = 2'(e);
    r.eov = 1'(f); r.evc = 1'(g); r.ef = 64'(h); r.eivr = 2'(i);
    return r;
  endfunction
  typedef struct {
    logic [63:0] f;
    int          t;
  } ent_t;
  ent_t mq[NV][$];
  int   rq_vc[$];
  int   rq_t[$];
  int   cred[NV];
  bit   rdy_ok;
  int   lock;
  int   last;
  int   cyc = 0;
  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      cred[v] = BD;
    end
    rq_vc.delete();
    rq_t.delete();
    rdy_ok = 0;
    lock = -1;
    last = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; iv = 1'b0; ordy = 1'b0; ovr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic model_cycle();
    logic [NV-1:0] er;
    bit ev;
    int sel;
    int e;
    for (int v = 0; v < NV; v++) er[v] = rdy_ok && (cred[v] > 0);
    ev = 0;
    sel = 0;
    if (lock >= 0) begin
      ev = 1;
      sel = lock;
    end else begin
      for (int i = 1; i <= NV; i++) begin
        int v;
        v = (last + i) % NV;
        if (!ev && mq[v].size() > 0 && mq[v][0].t <= cyc && ovr[v]) begin
          ev = 1;
          sel = v;
        end
      end
    end
    chk("rnd_in_vc_ready", ivr, er);
    chk("rnd_in_ready", irdy, er[ivc]);
    chk("rnd_out_valid", ov, ev);
    if (ev) begin
      chk("rnd_out_vc", ovc, sel);
      chk("rnd_out_flit", oflit, mq[sel][0].f);
    end
    e = cyc + 1;
    if (iv && er[ivc]) begin
      cred[ivc]--;
      mq[ivc].push_back('{iflit, e + ST});
    end
    if (ev && ordy) begin
      void'(mq[sel].pop_front());
      last = sel;
      lock = -1;
      rq_vc.push_back(sel);
      rq_t.push_back(e + ST);
    end else if (ev) lock = sel;
    while (rq_t.size() > 0 && rq_t[0] == e) begin
      cred[rq_vc.pop_front()]++;
      void'(rq_t.pop_front());
    end
    rdy_ok = 1;
    cyc = e;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int nout, prev, gaps;
    tbl[0]  = mk(0, 0, 0,     1, 3, 0, 0, 0,     0);
    tbl[1]  = mk(1, 1, 'hA1,  1, 3, 0, 0, 0,     3);
    tbl[2]  = mk(0, 0, 0,     1, 3, 0, 0, 0,     3);
    tbl[3]  = mk(0, 0, 0,     1, 3, 0, 0, 0,     3);
    tbl[4]  = mk(0, 0, 0,     1, 3, 1, 1, 'hA1,  3);
    tbl[5]  = mk(0, 0, 0,     1, 3, 0, 0, 0,     3);
    tbl[6]  = mk(1, 0, 'hB0,  0, 3, 0, 0, 0,     3);
    tbl[7]  = mk(1, 0, 'hB1,  0, 3, 0, 0, 0,     3);
    tbl[8]  = mk(1, 0, 'hB2,  0, 3, 0, 0, 0,     3);
    tbl[9]  = mk(1, 0, 'hB3,  0, 3, 1, 0, 'hB0,  3);
    tbl[10] = mk(1, 0, 'hB4,  0, 3, 1, 0, 'hB0,  3);
    tbl[11] = mk(1, 0, 'hB5,  0, 3, 1, 0, 'hB0,  3);
    tbl[12] = mk(1, 0, 'hB6,  0, 3, 1, 0, 'hB0,  2);
    tbl[13] = mk(1, 1, 'hC0,  0, 3, 1, 0, 'hB0,  2);
    tbl[14] = mk(0, 0, 0,     0, 2, 1, 0, 'hB0,  2);
    tbl[15] = mk(0, 0, 0,     0, 0, 1, 0, 'hB0,  2);
    tbl[16] = mk(0, 0, 0,     0, 2, 1, 0, 'hB0,  2);
    tbl[17] = mk(0, 0, 0,     1, 3, 1, 0, 'hB0,  2);
    tbl[18] = mk(0, 0, 0,     0, 3, 1, 1, 'hC0,  2);
    tbl[19] = mk(0, 0, 0,     1, 3, 1, 1, 'hC0,  2);
    tbl[20] = mk(0, 0, 0,     1, 3, 1, 0, 'hB1,  3);
    tbl[21] = mk(0, 0, 0,     0, 1, 1, 0, 'hB2,  3);
    #1;
    chk("reset_out_valid", ov, 0);
    chk("reset_in_vc_ready", ivr, 0);
    do_reset();
    for (int i = 0; i < 22; i++) begin
      iv = tbl[i].iv; ivc = tbl[i].vc; iflit = tbl[i].f; ordy = tbl[i].ordy; ovr = tbl[i].ovr;
      #1;
      chk($sformatf("tbl%0d_out_valid", i), ov, tbl[i].eov);
      if (tbl[i].eov) begin
        chk($sformatf("tbl%0d_out_vc", i), ovc, tbl[i].evc);
        chk($sformatf("tbl%0d_out_flit", i), oflit, tbl[i].ef);
      end
      chk($sformatf("tbl%0d_in_vc_ready", i), ivr, tbl[i].eivr);
      chk($sformatf("tbl%0d_in_ready", i), irdy, tbl[i].eivr[tbl[i].vc]);
      @(negedge clk);
    end
    // Round-robin: fill both FIFOs with nothing eligible, then drain
    do_reset();
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      iv = 1'b1; ivc = (j < 3) ? 1'b0 : 1'b1; iflit = 64'('h100 + j);
      @(negedge clk);
    end
    iv = 1'b0;
    repeat (4) @(negedge clk);
    ovr = 2'b11; ordy = 1'b1;
    for (int j = 0; j < 6; j++) begin
      #1;
      chk($sformatf("rr%0d_out_valid", j), ov, 1);
      chk($sformatf("rr%0d_out_vc", j), ovc, (j + 1) % 2);
      chk($sformatf("rr%0d_out_flit", j), oflit, (j % 2 == 0) ? 64'('h103 + j / 2) : 64'('h100 + j / 2));
      @(negedge clk);
    end
    #1;
    chk("rr_drained", ov, 0);
    // Streaming on one VC
    do_reset();
    @(negedge clk);
    ovr = 2'b11; ordy = 1'b1;
    nout = 0; prev = 0; gaps = 0;
    for (int c = 0; c < 110; c++) begin
      iv = (c < 100); ivc = 1'b0; iflit = 64'('h5000 + c);
      #1;
      if (c < 100) chk($sformatf("stream%0d_in_ready", c), irdy, 1);
      if (ov) begin
        chk($sformatf("stream%0d_flit", nout), oflit, 64'('h5000 + nout));
        if (nout > 0 && c != prev + 1) gaps++;
        prev = c;
        nout++;
      end
      @(negedge clk);
    end
    chk("stream_count", nout, 100);
    chk("stream_gaps", gaps, 0);
    // Mid-run reset with flits buffered and in flight
    do_reset();
    @(negedge clk);
    ovr = 2'b11; ordy = 1'b0;
    for (int j = 0; j < 2; j++) begin
      iv = 1'b1; ivc = 1'b0; iflit = 64'('hD00 + j);
      @(negedge clk);
    end
    iv = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mrst_pre_out_valid", ov, 1);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      iv = 1'b1; ivc = 1'b1; iflit = 64'('hE00 + j);
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", ov, 0);
    chk("mrst_in_vc_ready", ivr, 0);
    @(negedge clk);
    iv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst_release_in_vc_ready", ivr, 3);
    ordy = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mrst_stale%0d", j), ov, 0);
    end
    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      iv = ($urandom_range(0, 9) < 7);
      ivc = 1'($urandom_range(0, 1));
      iflit = {$urandom, $urandom};
      ordy = ($urandom_range(0, 9) < 6);
      for (int v = 0; v < NV; v++) ovr[v] = ($urandom_range(0, 3) != 0);
      #1;
      model_cycle();
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
